seq_mult: RTL and testbench
===========================

# seq_mult

Parametrised sequential shift-add multiplier for the Multiplicador datapath: an N×N multiply with a run-time unsigned/signed mode select, a start/done handshake and a synchronous reset. It integrates the controller (IDLE/ADD/SHIFT/DONE FSM with an internal bit counter) and its datapath registers in one block. It sits wherever a multi-cycle product is acceptable in exchange for a single N+1-bit adder.

## Interface
- N, 8, operand width in bits; legal range N ≥ 2.
- Clk  in  1  clock; all state changes on the rising edge.
- Rst  in  1  synchronous reset, active-high.
- St  in  1  start request; sampled only in IDLE.
- Sgn  in  1  mode: 0 = unsigned, 1 = two's-complement signed; captured with the operands at start.
- Mcand  in  N  multiplicand; captured at start.
- Mplier  in  N  multiplier; captured at start.
- P  out  2N  product; registered, held until the next accepted start.
- Idle  out  1  high in IDLE.
- Busy  out  1  high in ADD and SHIFT.
- Done  out  1  one-cycle pulse in DONE; P is valid from this cycle on.

## Operation
- Registers: ACC (N+1 bits), Q (N bits, multiplier/low product), B (N bits, multiplicand), mode bit S, counter K (ceil(log2(N+1)) bits).
- IDLE: if St is high, load ACC=0, Q=Mplier, B=Mcand, S=Sgn, K=0, and go to ADD. Otherwise stay.
- ADD: if Q[0]=1, ACC = ACC + ext(B). If S=1 and K=N−1, subtract instead: ACC = ACC − ext(B). ext() zero-extends B to N+1 bits when S=0 and sign-extends it when S=1. If Q[0]=0, ACC is unchanged. Go to SHIFT.
- SHIFT: shift {ACC,Q} right by 1. The new ACC[N] is 0 when S=0 and ACC[N] when S=1 (arithmetic shift). K=K+1. If the new K equals N, go to DONE; else go to ADD.
- DONE: P={ACC[N-1:0],Q}, Done=1, then go to IDLE.
- ACC is N+1 bits, so no intermediate overflow is possible in either mode. The result is exact modulo 2^2N.
- St while not in IDLE: ignored, not queued. Mcand, Mplier and Sgn may change freely after the start edge.
- St held high continuously: a new operation starts on every return to IDLE, with one IDLE cycle between runs.
- Undefined state encodings: go to IDLE (safe encoding).

## Timing
- Reset values: state IDLE, ACC=Q=B=0, S=0, K=0, P=0. Outputs: Idle=1, Busy=0, Done=0.
- Rst asserted mid-operation: the operation is aborted at that edge, no Done is produced, and P returns to 0.
- Call the edge at which St is accepted "edge 0". Then:
  - ADD/SHIFT alternate on edges 1..2N.
  - The state is DONE after edge 2N, so Done is high for exactly one cycle, 2N cycles after acceptance.
  - The block is back in IDLE after edge 2N+1.
- Throughput: one product per 2N+2 cycles with St held high.
- Idle, Busy and Done are decoded from the state register only, with no combinational path from inputs.

## Structure
- Shared package mult_pkg holds:
  - state encoding constants S_IDLE=0, S_ADD=1, S_SHIFT=2, S_DONE=3 (2-bit state type);
  - the counter-width function clog2.
- Natural split: one sub-module, seq_mult_ctrl, containing the FSM and the K counter. It takes Q[0] and K==N as inputs and drives Load, Add, Sub, Sh and Done strobes to the datapath in seq_mult.

## Test plan
- Unsigned, N=8: Sgn=0, Mcand=255, Mplier=255 → P=0xFE01, with Done exactly 16 cycles after the St edge.
- Signed, N=8, covering the most-negative and mixed-sign cases:
  - Sgn=1, Mcand=−128 (0x80), Mplier=−128 → P=0x4000.
  - Sgn=1, Mcand=−3 (0xFD), Mplier=5 → P=0xFFF1.
- Zero and mode independence, N=8: Mcand=0x5A, Mplier=0, in both modes → P=0x0000. Then Sgn=0, Mcand=0xFD, Mplier=5 → P=0x04F1, showing the same operand bits give a different result per mode.
- Handshake, N=8: pulse St during Busy with other operands → ignored, and the first result is unchanged. Hold St high → back-to-back results every 18 cycles, with Idle high for exactly one cycle between runs.
- Reset mid-operation: assert Rst at edge 5 of a run → next cycle Idle=1, Busy=0, P=0, and no Done. A fresh start then computes 12×11=132 (0x0084) correctly.
- Parameter N=4, Sgn=1: Mcand=−8 (0x8), Mplier=7 → P=0xC8, with Done 8 cycles after the start edge.

Source files
------------

// File: rtl/mult_pkg.sv
// mult_pkg: shared state encoding and width helper for the shift-add multiplier.
package mult_pkg;
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADD   = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/seq_mult_if.sv
// seq_mult_if: operand/result handshake bundle between a requester and seq_mult.
interface seq_mult_if #(parameter int N = 8);
    logic           st;
    logic           sgn;
    logic [N-1:0]   mcand;
    logic [N-1:0]   mplier;
    logic [2*N-1:0] p;
    logic           idle;
    logic           busy;
    logic           done;
    modport master(output st, sgn, mcand, mplier, input p, idle, busy, done);
    modport slave(input st, sgn, mcand, mplier, output p, idle, busy, done);
endinterface

// File: rtl/seq_mult_ctrl.sv
// seq_mult_ctrl: IDLE/ADD/SHIFT/DONE sequencer with the bit counter; drives datapath strobes.
module seq_mult_ctrl
    import mult_pkg::*;
#(
    parameter int N = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic st_i,
    input  logic q0_i,
    input  logic s_i,
    output logic load_o,
    output logic add_o,
    output logic sub_o,
    output logic sh_o,
    output logic fin_o,
    output logic idle_o,
    output logic busy_o,
    output logic done_o
);
    localparam int KW = clog2(N + 1);
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    state_t        state_q;
    logic [KW-1:0] k_q;
    logic          last;

    assign last = k_q == K_LAST;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (st_i) begin
                    state_q <= S_ADD;
                    k_q     <= '0;
                end
                S_ADD:   state_q <= S_SHIFT;
                S_SHIFT: begin
                    state_q <= last ? S_DONE : S_ADD;
                    k_q     <= k_q + KW'(1);
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // The final partial product carries negative weight in signed mode.
    assign load_o = state_q == S_IDLE && st_i;
    assign add_o  = state_q == S_ADD && q0_i && !(s_i && last);
    assign sub_o  = state_q == S_ADD && q0_i && s_i && last;
    assign sh_o   = state_q == S_SHIFT;
    assign fin_o  = state_q == S_SHIFT && last;
    assign idle_o = state_q == S_IDLE;
    assign busy_o = state_q == S_ADD || state_q == S_SHIFT;
    assign done_o = state_q == S_DONE;
endmodule

// File: rtl/seq_mult.sv
// seq_mult: N x N shift-add multiplier, unsigned or two's-complement, start/done handshake.
module seq_mult
    import mult_pkg::*;
#(
    parameter int N = 8
) (
    input logic       clk,
    input logic       rst,
    seq_mult_if.slave bus
);
    logic [N:0]     acc_q, acc_d, ext_b, acc_sum;
    logic [N-1:0]   q_q, q_d, b_q, b_d;
    logic           s_q, s_d;
    logic [2*N-1:0] p_q, p_d;
    logic           load, add, sub, sh, fin;

    seq_mult_ctrl #(.N(N)) u_ctrl (
        .clk    (clk),
        .rst    (rst),
        .st_i   (bus.st),
        .q0_i   (q_q[0]),
        .s_i    (s_q),
        .load_o (load),
        .add_o  (add),
        .sub_o  (sub),
        .sh_o   (sh),
        .fin_o  (fin),
        .idle_o (bus.idle),
        .busy_o (bus.busy),
        .done_o (bus.done)
    );

    assign ext_b   = {s_q & b_q[N-1], b_q};
    assign acc_sum = sub ? acc_q - ext_b : acc_q + ext_b;

    // The product is captured on the last shift so it is already valid while Done is high.
    always_comb begin
        acc_d = load ? '0 : (add || sub) ? acc_sum : sh ? {s_q & acc_q[N], acc_q[N:1]} : acc_q;
        q_d   = load ? bus.mplier : sh ? {acc_q[0], q_q[N-1:1]} : q_q;
        b_d   = load ? bus.mcand : b_q;
        s_d   = load ? bus.sgn : s_q;
        p_d   = fin ? {acc_q, q_q[N-1:1]} : p_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            q_q   <= '0;
            b_q   <= '0;
            s_q   <= 1'b0;
            p_q   <= '0;
        end else begin
            acc_q <= acc_d;
            q_q   <= q_d;
            b_q   <= b_d;
            s_q   <= s_d;
            p_q   <= p_d;
        end
    end

    assign bus.p = p_q;
endmodule

// File: tb/tb_seq_mult.sv
// tb_seq_mult: directed vectors for seq_mult at N=8 and N=4.
module tb_seq_mult;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    seq_mult_if #(.N(8)) b8 ();
    seq_mult_if #(.N(4)) b4 ();

    seq_mult #(.N(8)) dut8 (.clk(clk), .rst(rst), .bus(b8));
    seq_mult #(.N(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run8(input logic sg, input logic [7:0] mc, input logic [7:0] mp, output int cyc);
        @(negedge clk);
        b8.st = 1'b1; b8.sgn = sg; b8.mcand = mc; b8.mplier = mp;
        @(posedge clk); #1;
        b8.st = 1'b0; b8.mcand = 8'hxx; b8.mplier = 8'hxx; b8.sgn = 1'bx;
        cyc = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (b8.done) break;
        end
        @(posedge clk); #1;
        b8.sgn = 1'b0; b8.mcand = '0; b8.mplier = '0;
    endtask

    task automatic run4(input logic sg, input logic [3:0] mc, input logic [3:0] mp, output int cyc);
        @(negedge clk);
        b4.st = 1'b1; b4.sgn = sg; b4.mcand = mc; b4.mplier = mp;
        @(posedge clk); #1;
        b4.st = 1'b0;
        cyc = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (b4.done) break;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int cyc, d0, d1, idles, dones;
        b8.st = 0; b8.sgn = 0; b8.mcand = 0; b8.mplier = 0;
        b4.st = 0; b4.sgn = 0; b4.mcand = 0; b4.mplier = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_idle", 32'(b8.idle), 1);
        chk("rst_busy", 32'(b8.busy), 0);
        chk("rst_done", 32'(b8.done), 0);
        chk("rst_p", 32'(b8.p), 0);
        @(negedge clk);
        rst = 1'b0;

        run8(0, 8'd255, 8'd255, cyc);
        chk("u_255x255", 32'(b8.p), 32'hFE01);
        chk("u_latency", cyc, 16);
        run8(1, 8'h80, 8'h80, cyc);
        chk("s_m128sq", 32'(b8.p), 32'h4000);
        run8(1, 8'hFD, 8'd5, cyc);
        chk("s_m3x5", 32'(b8.p), 32'hFFF1);
        run8(0, 8'h5A, 8'd0, cyc);
        chk("u_zero", 32'(b8.p), 0);
        run8(1, 8'hFD, 8'd5, cyc);
        run8(1, 8'h5A, 8'd0, cyc);
        chk("s_zero", 32'(b8.p), 0);
        run8(0, 8'hFD, 8'd5, cyc);
        chk("u_253x5", 32'(b8.p), 32'h04F1);

        // St during Busy must be dropped, not queued.
        @(negedge clk);
        b8.st = 1; b8.sgn = 0; b8.mcand = 8'd3; b8.mplier = 8'd7;
        @(posedge clk); #1;
        b8.st = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("hs_busy", 32'(b8.busy), 1);
        b8.st = 1; b8.mcand = 8'd9; b8.mplier = 8'd9;
        @(posedge clk); #1;
        b8.st = 0;
        cyc = 4;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (b8.done) break;
        end
        chk("hs_p", 32'(b8.p), 32'h0015);
        chk("hs_latency", cyc, 16);
        repeat (4) @(posedge clk);
        #1;
        chk("hs_no_rerun", 32'(b8.idle), 1);
        chk("hs_p_hold", 32'(b8.p), 32'h0015);

        // Held start: runs back to back with a single IDLE cycle in between.
        @(negedge clk);
        b8.st = 1; b8.mcand = 8'd2; b8.mplier = 8'd3;
        d0 = -1; d1 = -1; idles = 0;
        for (int i = 0; i < 36; i++) begin
            @(posedge clk); #1;
            if (b8.done) begin
                if (d0 < 0) d0 = i;
                else if (d1 < 0) d1 = i;
            end
            if (b8.idle && d0 >= 0 && d1 < 0) idles++;
        end
        b8.st = 0;
        chk("bb_first", d0, 16);
        chk("bb_period", d1 - d0, 18);
        chk("bb_idle_gap", idles, 1);
        chk("bb_p", 32'(b8.p), 32'h0006);
        @(posedge clk); #1;
        chk("bb_end_idle", 32'(b8.idle), 1);

        // Abort at edge 5 of a run.
        @(negedge clk);
        b8.st = 1; b8.mcand = 8'd12; b8.mplier = 8'd11;
        @(posedge clk); #1;
        b8.st = 0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        chk("ab_idle", 32'(b8.idle), 1);
        chk("ab_busy", 32'(b8.busy), 0);
        chk("ab_p", 32'(b8.p), 0);
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (b8.done) dones++;
        end
        chk("ab_no_done", dones, 0);
        run8(0, 8'd12, 8'd11, cyc);
        chk("ab_restart", 32'(b8.p), 32'h0084);

        run4(1, 4'h8, 4'd7, cyc);
        chk("n4_m8x7", 32'(b4.p), 32'hC8);
        chk("n4_latency", cyc, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
